// File: rtl/mode_ctrl_pkg.sv
// Shared types and defaults for the button-driven mode controller.
// Debounce FSM state encoding and default qualification length.
package mode_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/mode_ctrl_debounce_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Synchronous active-high reset clears both stages to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/mode_ctrl_debounce.sv
// Push-button front end: synchronize, debounce, and toggle the counter direction
// once per accepted press. Also exports a press pulse and the debounced level.
module mode_ctrl_debounce
  import mode_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic mode,
  output logic press_pulse,
  output logic btn_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_s;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             press_pulse_q, press_pulse_d;
  logic             btn_stable_q, btn_stable_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      press_pulse_q <= 1'b0;
      btn_stable_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      press_pulse_q <= press_pulse_d;
      btn_stable_q  <= btn_stable_d;
    end
  end

  // The counter holds the number of consecutive qualifying samples already seen,
  // so the N-th sample arrives while cnt == N-1 and cnt never reaches N.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    press_pulse_d = 1'b0;
    btn_stable_d  = btn_stable_q;

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      PRESS_CHK: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
          mode_d        = ~mode_q;
          btn_stable_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      RELEASE_CHK: begin
        if (btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = IDLE;
          cnt_d        = '0;
          btn_stable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mode        = mode_q;
  assign press_pulse = press_pulse_q;
  assign btn_stable  = btn_stable_q;

endmodule

// File: doc/mode_ctrl_debounce.md
Name: mode_ctrl_debounce

Overview:
- Upstream control stage for the 2-bit up/down counter; produces its `mode` input from a raw push-button.
- Synchronizes the asynchronous button, debounces it with a qualification counter and an FSM, and toggles `mode` once per qualified press.
- Also exports a one-cycle press pulse and the debounced button level, for status and LEDs.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive identical synchronized samples required to accept a press or a release; legal range 2..65535.
- CNT_W, default 16: width of the qualification counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn_raw  in  1  asynchronous, bouncy button input; 1 = pressed.
- mode  out  1  counter direction select; registered; toggles once per accepted press.
- press_pulse  out  1  registered; high for exactly one cycle per accepted press.
- btn_stable  out  1  registered debounced button level.

Behaviour:
- Reset:
  - Reset is synchronous, active-high, on clk.
  - While rst=1 at a clk edge: both synchronizer flops = 0, state = IDLE, cnt = 0, mode = 0, press_pulse = 0, btn_stable = 0.
  - Reset asserted mid-qualification abandons the qualification; no pulse and no toggle are produced.
- Synchronizer:
  - Two-flop chain btn_raw -> s1 -> btn_s.
  - Only btn_s feeds the FSM; btn_raw is never used elsewhere.
- FSM states: IDLE, PRESS_CHK, PRESSED, RELEASE_CHK. Let N = DEBOUNCE_CYCLES.
  - IDLE: btn_s=1 -> PRESS_CHK, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_CHK: btn_s=0 -> IDLE, cnt<=0 (glitch rejected). btn_s=1 and cnt==N-1 -> PRESSED, cnt<=0, press_pulse<=1, mode<=~mode, btn_stable<=1. Otherwise cnt<=cnt+1.
  - PRESSED: btn_s=0 -> RELEASE_CHK, cnt<=1. Otherwise stay; no auto-repeat, however long the button is held.
  - RELEASE_CHK: btn_s=1 -> PRESSED, cnt<=0. btn_s=0 and cnt==N-1 -> IDLE, cnt<=0, btn_stable<=0. Otherwise cnt<=cnt+1.
  - Release produces no pulse and leaves mode unchanged.
- press_pulse defaults to 0 every cycle unless the PRESS_CHK->PRESSED transition fires.
- Latency:
  - btn_raw stable high from before edge k -> press_pulse, mode change and btn_stable=1 are visible after edge k+1+N.
  - press_pulse is low again after edge k+2+N.
  - Release is symmetric: btn_stable=0 after edge k+1+N.
- Width rule: cnt never exceeds N-1; no wrap-around is possible.
- Any bounce shorter than N samples, in either checking state, returns to the prior stable state with no output change.
- Illegal state encoding -> IDLE, cnt<=0; mode is unchanged.

Decomposition:
- Shared package `mode_ctrl_pkg`:
  - State typedef (2-bit enum: IDLE=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3).
  - Default constant DEBOUNCE_CYCLES_DEF=16.
- One sub-module, `sync2`: a two-flop synchronizer with the same clk and synchronous active-high rst; reset value 0.
- FSM, counter and output registers live in the top module.

Test Plan:
- Reset, then btn_raw=0 held for 50 cycles, N=4 -> mode=0, press_pulse=0, btn_stable=0 throughout.
- btn_raw rises before edge 10 and is held, N=4 -> press_pulse high only after edge 15, mode=1 and btn_stable=1 from edge 15 on; no further pulses while held for 100 cycles.
- Bounce train, N=4: btn_raw high 3 cycles, low 1, high 2, low 1, then stable high -> exactly one pulse, issued 5 edges after the final stable rise; mode toggles once.
- Three clean press/release cycles (high 10 cycles, low 10 cycles), N=4 -> mode sequence 1,0,1; three pulses; btn_stable falls 5 edges after each release.
- Release bounce: while in PRESSED, btn_raw low for 2 cycles, then high -> btn_stable stays 1, no pulse, mode unchanged.
- Reset mid-qualification: rst=1 for one edge while in PRESS_CHK with cnt=2, btn_raw held high -> all outputs 0; a fresh qualification runs, with the pulse after edge r+1+N following reset release at edge r.
